// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and glitch-filters encoder phases, emits step pulses.
// Latency: pin change to pulse is SYNC_STAGES + FILTER_LEN clock edges; pulses last one cycle.
// Backpressure: none; pulses are fire-and-forget, en=0 drops pulses while level tracking continues.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       en,
    input  logic       clr_fault,
    output logic       increment,
    output logic       decrement,
    output logic       error,
    output logic       fault,
    output logic [1:0] ab_state
);

    // stab only needs to reach FILTER_LEN-1 (run length minus the first sighting).
    localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [SYNC_STAGES-1:0] sync_ok;
    logic [1:0]             s;
    logic [1:0]             s_prev;
    logic [STAB_W-1:0]      stab;
    logic [STAB_W-1:0]      stab_next;
    logic                   sync_full;
    logic                   stable;
    logic                   primed;
    logic                   moved;
    logic [1:0]             step;

    // Position along the forward cycle 00->10->11->01; the difference of two
    // positions mod 4 classifies a step: 1 forward, 3 reverse, 2 illegal jump.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Synchroniser chains; sync_ok marks when the chain holds real pin samples
    // again after reset, so the zeros flushed in by reset are never accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            sync_ok <= '0;
        end else begin
            sync_a  <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b  <= {sync_b[SYNC_STAGES-2:0], enc_b};
            sync_ok <= {sync_ok[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s         = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign sync_full = sync_ok[SYNC_STAGES-1];

    // Saturating run length of identical synchronised samples at this edge.
    always_comb begin
        stab_next = '0;
        if (sync_full && (s == s_prev)) begin
            stab_next = (stab == STAB_MAX) ? stab : stab + 1'b1;
        end
    end

    assign stable = sync_full && (stab_next == STAB_MAX);
    assign moved  = stable && primed && (s != ab_state);
    assign step   = gray_pos(s) - gray_pos(ab_state);

    // Level acceptance, priming, registered step pulses and the sticky fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev    <= 2'b00;
            stab      <= '0;
            primed    <= 1'b0;
            ab_state  <= 2'b00;
            increment <= 1'b0;
            decrement <= 1'b0;
            error     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            s_prev    <= s;
            stab      <= stab_next;
            increment <= moved && en && (step == 2'd1);
            decrement <= moved && en && (step == 2'd3);
            error     <= moved && en && (step == 2'd2);
            if (stable && (!primed || (s != ab_state))) begin
                ab_state <= s;
                primed   <= 1'b1;
            end
            // A new error outranks a simultaneous clear.
            if (moved && en && (step == 2'd2)) begin
                fault <= 1'b1;
            end else if (clr_fault) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with hand-computed pulse timing.
// Latency: pulses expected on the 5th sample after a pin change (default parameters).
// Backpressure: not applicable; outputs sampled 1 time unit after each rising edge.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       en;
    logic       clr_fault;
    logic       increment;
    logic       decrement;
    logic       error;
    logic       fault;
    logic [1:0] ab_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, n_inc, n_dec, n_err, inc_at, dec_at, err_at;

    quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .en        (en),
        .clr_fault (clr_fault),
        .increment (increment),
        .decrement (decrement),
        .error     (error),
        .fault     (fault),
        .ab_state  (ab_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; n_inc = 0; n_dec = 0; n_err = 0;
        inc_at = -1; dec_at = -1; err_at = -1;
    endtask

    // Advance n cycles, sampling 1 unit after each rising edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (increment === 1'b1) begin n_inc++; inc_at = cyc; end
            if (decrement === 1'b1) begin n_dec++; dec_at = cyc; end
            if (error === 1'b1)     begin n_err++; err_at = cyc; end
        end
    endtask

    // Drive a new AB level, hold it, and check pulse counts, timing and level.
    // exp = {inc, dec, err}; any expected pulse must appear on sample 5.
    task automatic apply_ab(input logic [1:0] ab, input int hold, input logic [2:0] exp,
                            input logic [1:0] exp_ab, input string tag);
        int at;
        clear_mon();
        enc_a = ab[1];
        enc_b = ab[0];
        run(hold);
        at = inc_at;
        if (dec_at > at) at = dec_at;
        if (err_at > at) at = err_at;
        chk({tag, "_inc"}, n_inc, int'(exp[2]));
        chk({tag, "_dec"}, n_dec, int'(exp[1]));
        chk({tag, "_err"}, n_err, int'(exp[0]));
        chk({tag, "_at"}, at, (exp == 3'b000) ? -1 : 5);
        chk({tag, "_ab"}, int'(ab_state), int'(exp_ab));
    endtask

    initial begin
        reset = 1'b0; enc_a = 1'b0; enc_b = 1'b0; en = 1'b1; clr_fault = 1'b0;
        #1;
        chk("rst_ab", int'(ab_state), 0);
        chk("rst_pulses", int'({increment, decrement, error}), 0);
        chk("rst_fault", int'(fault), 0);

        // 1: reset 3 cycles, release at AB=00, quiet for 10 cycles
        run(3);
        reset = 1'b1;
        clear_mon();
        run(10);
        chk("t1_pulses", n_inc + n_dec + n_err, 0);
        chk("t1_ab", int'(ab_state), 0);
        chk("t1_fault", int'(fault), 0);

        // 2: forward cycle
        apply_ab(2'b10, 8, 3'b100, 2'b10, "t2_10");
        apply_ab(2'b11, 8, 3'b100, 2'b11, "t2_11");
        apply_ab(2'b01, 8, 3'b100, 2'b01, "t2_01");
        apply_ab(2'b00, 8, 3'b100, 2'b00, "t2_00");

        // 3: reverse cycle
        apply_ab(2'b01, 8, 3'b010, 2'b01, "t3_01");
        apply_ab(2'b11, 8, 3'b010, 2'b11, "t3_11");
        apply_ab(2'b10, 8, 3'b010, 2'b10, "t3_10");
        apply_ab(2'b00, 8, 3'b010, 2'b00, "t3_00");

        // 4: 2-cycle glitch on A is filtered out
        clear_mon();
        enc_a = 1'b1;
        run(2);
        enc_a = 1'b0;
        run(8);
        chk("t4_glitch_pulses", n_inc + n_dec + n_err, 0);
        chk("t4_glitch_ab", int'(ab_state), 0);
        // 3-cycle pulse on A passes: increment at 5, then back 10->00 decrement at 8
        clear_mon();
        enc_a = 1'b1;
        run(3);
        enc_a = 1'b0;
        run(8);
        chk("t4_pass_inc_n", n_inc, 1);
        chk("t4_pass_inc_at", inc_at, 5);
        chk("t4_pass_dec_n", n_dec, 1);
        chk("t4_pass_dec_at", dec_at, 8);
        chk("t4_pass_ab", int'(ab_state), 0);

        // 5: illegal jump, sticky fault, clear, then a legal step
        apply_ab(2'b11, 8, 3'b001, 2'b11, "t5_jump");
        chk("t5_fault_set", int'(fault), 1);
        clr_fault = 1'b1;
        run(1);
        clr_fault = 1'b0;
        chk("t5_fault_clr", int'(fault), 0);
        apply_ab(2'b01, 8, 3'b100, 2'b01, "t5_step");

        // en=0: level still tracks, step is lost
        en = 1'b0;
        apply_ab(2'b00, 8, 3'b000, 2'b00, "en0");
        chk("en0_fault", int'(fault), 0);
        en = 1'b1;

        // 6: reset while the increment pulse is high, then re-prime at 11
        apply_ab(2'b10, 5, 3'b100, 2'b10, "t6_pre");
        #2 reset = 1'b0;
        #1;
        chk("t6_async_inc", int'(increment), 0);
        chk("t6_async_ab", int'(ab_state), 0);
        enc_a = 1'b1;
        enc_b = 1'b1;
        run(2);
        reset = 1'b1;
        clear_mon();
        run(10);
        chk("t6_prime_pulses", n_inc + n_dec + n_err, 0);
        chk("t6_prime_ab", int'(ab_state), 3);
        chk("t6_prime_fault", int'(fault), 0);
        apply_ab(2'b01, 8, 3'b100, 2'b01, "t6_step");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
